// File: rtl/a_seq_pkg.sv
// Shared constants, FSM state encoding and skid-buffer entry layout for the A-matrix ROM sequencer.
package a_seq_pkg;

  localparam int ADDR_W        = 4;
  localparam int DATA_W        = 14;
  localparam int ELEM_W        = 7;
  localparam int N_COLS        = 4;
  localparam int WORDS_PER_COL = (2 ** ADDR_W) / N_COLS;
  localparam int ROWP_W        = $clog2(WORDS_PER_COL);
  localparam int COL_W         = ADDR_W - ROWP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seqState_e;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } seqEntry_t;

  localparam int ENTRY_W = $bits(seqEntry_t);

  function automatic logic [ADDR_W-1:0] colFirstAddr(input logic [N_COLS-1:0] mask);
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int c = N_COLS - 1; c >= 0; c--) begin
      if (mask[c[COL_W-1:0]]) a = ADDR_W'(c * WORDS_PER_COL);
    end
    return a;
  endfunction

  function automatic logic [ADDR_W-1:0] colLastAddr(input logic [N_COLS-1:0] mask);
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (mask[c[COL_W-1:0]]) a = ADDR_W'(c * WORDS_PER_COL + WORDS_PER_COL - 1);
    end
    return a;
  endfunction

  // Step down the current column; at its bottom jump to the top of the next enabled column.
  function automatic logic [ADDR_W-1:0] colNextAddr(input logic [ADDR_W-1:0] addr,
                                                    input logic [N_COLS-1:0] mask);
    logic [ADDR_W-1:0] n;
    n = addr;
    if (addr[ROWP_W-1:0] != ROWP_W'(WORDS_PER_COL - 1)) begin
      n = addr + ADDR_W'(1);
    end else begin
      for (int c = N_COLS - 1; c >= 0; c--) begin
        if (mask[c[COL_W-1:0]] && (c > int'(addr[ADDR_W-1:ROWP_W]))) n = ADDR_W'(c * WORDS_PER_COL);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/a_seq_skid.sv
// Two-entry FIFO skid buffer. When empty, the entry being pushed is presented at the head
// in the same cycle so a word arriving from the ROM can be consumed without a bubble.
module a_seq_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic             headValid_o,
  output logic [WIDTH-1:0] headData_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rdPtr_q, rdPtr_d;
  logic             wrPtr_q, wrPtr_d;
  logic [1:0]       count_q, count_d;
  logic             empty, store, drain;

  // A push that is popped straight through while empty never occupies a slot.
  always_comb begin
    empty   = (count_q == 2'd0);
    store   = push_i && !(empty && pop_i);
    drain   = pop_i && !empty;
    rdPtr_d = rdPtr_q ^ drain;
    wrPtr_d = wrPtr_q ^ store;
    count_d = count_q + {1'b0, store} - {1'b0, drain};
    if (flush_i) begin
      rdPtr_d = 1'b0;
      wrPtr_d = 1'b0;
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wrPtr_q] <= pushData_i;
  end

  assign headValid_o = !empty || push_i;
  assign headData_o  = empty ? pushData_i : mem_q[rdPtr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/a_rom_seq.sv
// Column-major sequencer for the 16-word A-matrix ROM, streaming unpacked element pairs.
// Define A_SEQ_COLMASK_EN to add col_mask_i, which skips disabled columns of a pass.
module a_rom_seq
  import a_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
`ifdef A_SEQ_COLMASK_EN
  input  logic [N_COLS-1:0] col_mask_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ELEM_W-1:0] out_elem_hi_o,
  output logic [ELEM_W-1:0] out_elem_lo_o,
  output logic [COL_W-1:0]  out_col_o,
  output logic [ROWP_W-1:0] out_rowp_o,
  output logic              out_last_o
);

  seqState_e         state_q, state_d;
  logic [N_COLS-1:0] colMask, mask_q, mask_d;
  logic [ADDR_W-1:0] nextAddr_q, nextAddr_d;
  logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
  logic [ADDR_W-1:0] romAddr_q;
  logic              pending_q, pending_d;
  logic              inflight_q, inflightLast_q;
  logic [ADDR_W-1:0] inflightAddr_q;
  logic              startAcc, issue, issueLast, pop;
  logic [2:0]        fill;
  logic              headValid;
  logic [ENTRY_W-1:0] headData;
  logic [1:0]        skidCount;
  seqEntry_t         pushEntry, headEntry;

`ifdef A_SEQ_COLMASK_EN
  assign colMask = col_mask_i;
`else
  assign colMask = '1;
`endif

  // fill is the buffer occupancy next cycle; only issue if the returning word will still fit.
  assign pop        = headValid && out_ready_i;
  assign fill       = {1'b0, skidCount} + {2'b0, inflight_q} - {2'b0, pop};
  assign startAcc   = (state_q == IDLE) && start_i && !abort_i;
  assign issue      = (state_q == RUN) && pending_q && !abort_i && (fill < 3'd2);
  assign issueLast  = issue && (nextAddr_q == lastAddr_q);
  assign rom_addr_o = issue ? nextAddr_q : romAddr_q;

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (startAcc) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (issueLast) state_d = DRAIN;
        else if (!pending_q) state_d = (fill == 3'd0) ? DONE : DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (fill == 3'd0) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_comb begin
    mask_d     = mask_q;
    nextAddr_d = nextAddr_q;
    lastAddr_d = lastAddr_q;
    pending_d  = pending_q;
    if (startAcc) begin
      mask_d     = colMask;
      nextAddr_d = colFirstAddr(colMask);
      lastAddr_d = colLastAddr(colMask);
      pending_d  = |colMask;
    end else if (issue) begin
      nextAddr_d = colNextAddr(nextAddr_q, mask_q);
      pending_d  = !issueLast;
    end
    if (abort_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      nextAddr_q     <= '0;
      lastAddr_q     <= '0;
      pending_q      <= 1'b0;
      romAddr_q      <= '0;
      inflight_q     <= 1'b0;
      inflightAddr_q <= '0;
      inflightLast_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      nextAddr_q     <= nextAddr_d;
      lastAddr_q     <= lastAddr_d;
      pending_q      <= pending_d;
      romAddr_q      <= rom_addr_o;
      inflight_q     <= issue;
      inflightLast_q <= issueLast;
      if (issue) inflightAddr_q <= nextAddr_q;
    end
  end

  assign pushEntry = '{last: inflightLast_q, addr: inflightAddr_q, data: rom_data_i};

  a_seq_skid #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (abort_i),
    .push_i     (inflight_q),
    .pushData_i (pushEntry),
    .pop_i      (pop),
    .headValid_o(headValid),
    .headData_o (headData),
    .count_o    (skidCount)
  );

  // Fields are forced to zero when nothing is offered so idle outputs read as 0.
  assign headEntry     = headValid ? seqEntry_t'(headData) : '0;
  assign out_valid_o   = headValid;
  assign out_elem_hi_o = headEntry.data[DATA_W-1:ELEM_W];
  assign out_elem_lo_o = headEntry.data[ELEM_W-1:0];
  assign out_col_o     = headEntry.addr[ADDR_W-1:ROWP_W];
  assign out_rowp_o    = headEntry.addr[ROWP_W-1:0];
  assign out_last_o    = headEntry.last;

endmodule
